// File: rtl/blk_3b6831_if.sv
`default_nettype none
// ============================================================================
// Module   : blk_3b6831_if
// Purpose  : Bundles the LUT6 configuration-chain and LUT-select signals.
//            master drives programming/select, slave is the LUT6 stage.
// Signals  : prog_en   - programming window, high = shift chain
//            ccff_head - serial config data in
//            ccff_tail - serial config data out to next tile
//            cfg_done  - active table holds a verified load
//            cfg_err   - last load rejected (length or parity)
//            lut6_in   - LUT select inputs
//            lut6_out  - selected truth-table bit
// Revision : 1.0 - initial release
// ============================================================================
interface blk_3b6831_if #(
  parameter int LUT_SIZE = 6
);
  logic                prog_en;
  logic                ccff_head;
  logic                ccff_tail;
  logic                cfg_done;
  logic                cfg_err;
  logic [LUT_SIZE-1:0] lut6_in;
  logic                lut6_out;

  modport master (
    output prog_en, ccff_head, lut6_in,
    input  ccff_tail, cfg_done, cfg_err, lut6_out
  );

  modport slave (
    input  prog_en, ccff_head, lut6_in,
    output ccff_tail, cfg_done, cfg_err, lut6_out
  );
endinterface
`default_nettype wire

// File: rtl/blk_3b6831.sv
`default_nettype none
// ============================================================================
// Module   : blk_3b6831
// Purpose  : LUT6 stage of the BLE6. The truth table is shifted serially into
//            a shadow register (64 table bits + 1 parity bit), checked for
//            length and even parity, then committed atomically to the active
//            table. A bad or short load never disturbs the active function.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-low reset
//            bus    - blk_3b6831_if.slave (config chain, status, LUT select)
// Revision : 1.0 - initial release
// ============================================================================
module blk_3b6831 #(
  parameter int LUT_SIZE = 6,
  parameter int CFG_BITS = 2 ** LUT_SIZE,
  parameter int CNT_W    = $clog2(CFG_BITS + 2)
) (
  input  logic          clk,
  input  logic          reset,
  blk_3b6831_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Exact chain length (table + parity) and the saturation value that marks
  // an over-length load.
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(CFG_BITS + 2);

  state_t              r_state;
  state_t              w_next_state;
  logic [CFG_BITS:0]   r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cfg_done;
  logic                r_cfg_err;
  logic                w_accept;

  // Even parity over all table bits plus the parity bit, and exact length.
  assign w_accept = (r_cnt == C_CNT_FULL) && !(^r_shadow);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.prog_en)  w_next_state = SHIFT;
      SHIFT:   if (!bus.prog_en) w_next_state = CHECK;
      CHECK:   w_next_state = IDLE;  // prog_en ignored here
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shadow chain, counter, commit and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_cnt      <= '0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.prog_en) begin
            // First bit of the window is captured on the entry edge.
            r_shadow  <= {r_shadow[CFG_BITS-1:0], bus.ccff_head};
            r_cnt     <= CNT_W'(1);
            r_cfg_err <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.prog_en) begin
            r_shadow <= {r_shadow[CFG_BITS-1:0], bus.ccff_head};
            if (r_cnt != C_CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (w_accept) begin
            // shadow[0] is the parity bit; the first bit shifted lands in
            // the table MSB.
            r_active   <= r_shadow[CFG_BITS:1];
            r_cfg_done <= 1'b1;
            r_cfg_err  <= 1'b0;
          end else begin
            r_cfg_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ccff_tail = r_shadow[CFG_BITS];
  assign bus.cfg_done  = r_cfg_done;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.lut6_out  = r_active[bus.lut6_in];

endmodule
`default_nettype wire
